apb_fifo_ctrl: RTL and testbench

APB_FIFO_CTRL -- requirements
Module: apb_fifo_ctrl

---
 rtl/apb_fifo_ctrl.sv | 174 +++++++++++++++++
 tb/tb_apb_fifo_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_fifo_ctrl.sv
// APB slave wrapping a FIFO controller around an external single-port-write,
// async-read memory. Every APB transfer takes exactly one wait state:
// IDLE (setup seen) -> ACCESS (side effects happen on the edge leaving it)
// -> DONE (pready=1, prdata/pslverr presented).
module apb_fifo_ctrl #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [3:0]    paddr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready,
  output logic          pslverr,
  output logic [AW-1:0] mem_a1,
  output logic [DW-1:0] mem_wd1,
  output logic          mem_we1,
  output logic [AW-1:0] mem_a2,
  input  logic [DW-1:0] mem_rd2,
  output logic          irq
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_THRESH = 2'd3
  } reg_t;

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  state_t        state, state_nxt;
  reg_t          sel;
  logic [AW:0]   wr_ptr, rd_ptr, count, thresh;
  logic          empty, full;
  logic          ovf, udf;
  logic          err_q, err_nxt;
  logic [DW-1:0] prdata_q, rd_val, status;
  logic          irq_q;
  logic          in_access, push_req, pop_req, do_push, do_pop;
  logic          ctrl_wr, flush, sticky_clr;
  logic          addr_unused;

  // Byte-lane bits of the address carry no meaning for word registers.
  assign addr_unused = ^paddr[1:0];

  assign sel   = reg_t'(paddr[3:2]);
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_access  = (state == ACCESS);
  assign push_req   = in_access &&  pwrite && (sel == REG_DATA);
  assign pop_req    = in_access && !pwrite && (sel == REG_DATA);
  assign do_push    = push_req && !full;
  assign do_pop     = pop_req  && !empty;
  assign ctrl_wr    = in_access && pwrite && (sel == REG_CTRL);
  assign flush      = ctrl_wr && pwdata[0];
  assign sticky_clr = ctrl_wr && pwdata[1];

  // Transfer state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  // NOTE: defaults first so no path through this block leaves a variable unassigned (no latches).
  always_comb begin
    state_nxt = state;
    pready    = 1'b0;
    unique case (state)
      IDLE:    if (psel && !penable) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE: begin
        pready    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // STATUS word assembly.
  always_comb begin
    status       = '0;
    status[AW:0] = count;
    status[16]   = empty;
    status[17]   = full;
    status[18]   = ovf;
    status[19]   = udf;
  end

  // Read data mux and error decode for the transfer sitting in ACCESS.
  always_comb begin
    rd_val  = '0;
    err_nxt = 1'b0;
    unique case (sel)
      REG_DATA: begin
        if (!pwrite && !empty) rd_val = mem_rd2;
        err_nxt = pwrite ? full : empty;
      end
      REG_STATUS: begin
        rd_val  = status;
        err_nxt = pwrite;
      end
      REG_CTRL:   err_nxt = !pwrite;
      REG_THRESH: rd_val[AW:0] = thresh;
      default:    err_nxt = 1'b0;
    endcase
  end

  // FIFO pointers: push advances wr_ptr, pop advances rd_ptr, flush drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (flush)       rd_ptr <= wr_ptr;
      else if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Sticky error flags; a set on the same edge as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (push_req && full) ovf <= 1'b1;
      else if (sticky_clr)  ovf <= 1'b0;
      if (pop_req && empty) udf <= 1'b1;
      else if (sticky_clr)  udf <= 1'b0;
    end
  end

  // Threshold register and registered level interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (in_access && pwrite && (sel == REG_THRESH)) thresh <= pwdata[AW:0];
      irq_q <= (thresh != '0) && (count >= thresh);
    end
  end

  // Response registers captured on the edge leaving ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prdata_q <= '0;
      err_q    <= 1'b0;
    end else if (in_access) begin
      if (!pwrite) prdata_q <= rd_val;
      err_q <= err_nxt;
    end
  end

  assign prdata  = prdata_q;
  assign pslverr = (state == DONE) && err_q;
  assign irq     = irq_q;
  assign mem_we1 = do_push;
  assign mem_wd1 = pwdata;
  assign mem_a1  = wr_ptr[AW-1:0];
  assign mem_a2  = rd_ptr[AW-1:0];

endmodule

// File: tb/tb_apb_fifo_ctrl.sv
// Directed bench for apb_fifo_ctrl with a behavioural memory attached.
module tb_apb_fifo_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;

  localparam logic [3:0] A_DATA   = 4'h0;
  localparam logic [3:0] A_STATUS = 4'h4;
  localparam logic [3:0] A_CTRL   = 4'h8;
  localparam logic [3:0] A_THRESH = 4'hC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [3:0]    paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;
  logic [AW-1:0] mem_a1, mem_a2;
  logic [DW-1:0] mem_wd1, mem_rd2;
  logic          mem_we1, irq;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int tests = 0;
  int fails = 0;

  // Per-transfer snapshots taken by the apb task.
  logic          s_we, s_irq_done;
  logic [AW-1:0] s_a1, s_a2;

  apb_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .mem_a1(mem_a1), .mem_wd1(mem_wd1), .mem_we1(mem_we1),
    .mem_a2(mem_a2), .mem_rd2(mem_rd2), .irq(irq)
  );

  always #5 clk = ~clk;

  // Behavioural memory: synchronous write, combinational read.
  always @(posedge clk) if (mem_we1) mem[mem_a1] <= mem_wd1;
  assign mem_rd2 = mem[mem_a2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One APB transfer; checks one wait state and a single-cycle pready pulse.
  task automatic apb(input logic wr, input logic [3:0] addr, input logic [DW-1:0] wdata,
                     output logic [DW-1:0] rdata, output logic err);
    int  waits;
    logic seen;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    s_we = mem_we1; s_a1 = mem_a1; s_a2 = mem_a2;
    waits = 0;
    seen  = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (pready) seen = 1'b1;
      else begin
        waits++;
        @(posedge clk); #1;
      end
    end
    rdata = prdata;
    err   = pslverr;
    s_irq_done = irq;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    check("wait_states", 64'(waits), 64'd1);
    check("pready_one_cycle", {63'd0, pready}, 64'd0);
  endtask

  logic [DW-1:0] rd;
  logic          er;
  int            bad;
  logic          wrap1, wrap2;
  logic [AW-1:0] last_a1, last_a2;

  initial begin
    // Reset state.
    #2;
    check("rst_pready",  {63'd0, pready},  64'd0);
    check("rst_pslverr", {63'd0, pslverr}, 64'd0);
    check("rst_prdata",  64'(prdata),      64'd0);
    check("rst_mem_we1", {63'd0, mem_we1}, 64'd0);
    check("rst_irq",     {63'd0, irq},     64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    apb(1'b0, A_STATUS, '0, rd, er);
    check("status_after_reset", 64'(rd), 64'h10000);

    // Basic push/pop ordering.
    apb(1'b1, A_DATA, 32'h11, rd, er); check("push11_err", {63'd0, er}, 64'd0);
    apb(1'b1, A_DATA, 32'h22, rd, er); check("push22_err", {63'd0, er}, 64'd0);
    apb(1'b1, A_DATA, 32'h33, rd, er); check("push33_err", {63'd0, er}, 64'd0);
    apb(1'b0, A_STATUS, '0, rd, er);   check("status_count3", 64'(rd), 64'h3);
    apb(1'b0, A_DATA, '0, rd, er);     check("pop11", 64'(rd), 64'h11);
    apb(1'b0, A_DATA, '0, rd, er);     check("pop22", 64'(rd), 64'h22);
    apb(1'b0, A_DATA, '0, rd, er);     check("pop33", 64'(rd), 64'h33);
    check("pop33_err", {63'd0, er}, 64'd0);
    apb(1'b0, A_STATUS, '0, rd, er);   check("status_empty", 64'(rd), 64'h10000);

    // Threshold interrupt and flush.
    apb(1'b1, A_THRESH, 32'd4, rd, er);
    apb(1'b0, A_THRESH, '0, rd, er);   check("thresh_rd", 64'(rd), 64'd4);
    for (int i = 0; i < 3; i++) apb(1'b1, A_DATA, 32'h40 + i, rd, er);
    check("irq_low_at_3", {63'd0, irq}, 64'd0);
    apb(1'b1, A_DATA, 32'h43, rd, er);
    check("irq_low_in_done_of_4th", {63'd0, s_irq_done}, 64'd0);
    check("irq_high_after_4th", {63'd0, irq}, 64'd1);
    apb(1'b1, A_CTRL, 32'h1, rd, er);
    check("irq_low_after_flush", {63'd0, irq}, 64'd0);
    apb(1'b0, A_STATUS, '0, rd, er);   check("status_after_flush", 64'(rd), 64'h10000);
    apb(1'b1, A_THRESH, 32'd0, rd, er);

    // Underflow and sticky clear.
    apb(1'b0, A_DATA, '0, rd, er);
    check("underflow_prdata", 64'(rd), 64'd0);
    check("underflow_err", {63'd0, er}, 64'd1);
    apb(1'b0, A_STATUS, '0, rd, er);   check("status_underflow", 64'(rd), 64'h90000);
    apb(1'b1, A_CTRL, 32'h2, rd, er);
    apb(1'b0, A_STATUS, '0, rd, er);   check("status_udf_cleared", 64'(rd), 64'h10000);

    // Illegal accesses.
    apb(1'b1, A_STATUS, 32'hFFFF_FFFF, rd, er); check("status_write_err", {63'd0, er}, 64'd1);
    apb(1'b0, A_CTRL, '0, rd, er);
    check("ctrl_read_err", {63'd0, er}, 64'd1);
    check("ctrl_read_zero", 64'(rd), 64'd0);
    apb(1'b0, A_STATUS, '0, rd, er);   check("status_no_side_effect", 64'(rd), 64'h10000);

    // Fill to full, then overflow.
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      apb(1'b1, A_DATA, 32'h1000 + 32'(i) * 3, rd, er);
      if (er !== 1'b0) bad++;
    end
    check("fill_errs", 64'(bad), 64'd0);
    apb(1'b1, A_DATA, 32'hDEAD, rd, er); check("overflow_err", {63'd0, er}, 64'd1);
    apb(1'b0, A_STATUS, '0, rd, er);    check("status_full", 64'(rd), 64'h60100);
    apb(1'b0, A_DATA, '0, rd, er);      check("pop_first_after_full", 64'(rd), 64'h1000);
    apb(1'b0, A_STATUS, '0, rd, er);    check("status_255", 64'(rd), 64'h400FF);
    bad = 0;
    for (int i = 1; i < 256; i++) begin
      apb(1'b0, A_DATA, '0, rd, er);
      if (rd !== 32'h1000 + 32'(i) * 3 || er !== 1'b0) bad++;
    end
    check("drain_order", 64'(bad), 64'd0);
    apb(1'b1, A_CTRL, 32'h3, rd, er);
    apb(1'b0, A_STATUS, '0, rd, er);    check("status_after_ctrl3", 64'(rd), 64'h10000);

    // Wrap-around with push/pop pairs.
    bad = 0; wrap1 = 1'b0; wrap2 = 1'b0; last_a1 = '0; last_a2 = '0;
    for (int i = 0; i < 300; i++) begin
      apb(1'b1, A_DATA, 32'hA5A5_0000 ^ 32'(i), rd, er);
      if (er !== 1'b0 || s_we !== 1'b1) bad++;
      if (i > 0 && last_a1 == 8'hFF && s_a1 == 8'h00) wrap1 = 1'b1;
      last_a1 = s_a1;
      apb(1'b0, A_DATA, '0, rd, er);
      if (er !== 1'b0 || s_we !== 1'b0 || rd !== (32'hA5A5_0000 ^ 32'(i))) bad++;
      if (i > 0 && last_a2 == 8'hFF && s_a2 == 8'h00) wrap2 = 1'b1;
      last_a2 = s_a2;
    end
    check("wrap_data", 64'(bad), 64'd0);
    check("wrap_a1", {63'd0, wrap1}, 64'd1);
    check("wrap_a2", {63'd0, wrap2}, 64'd1);
    apb(1'b0, A_STATUS, '0, rd, er);    check("status_after_wrap", 64'(rd), 64'h10000);

    // Reset asserted in the ACCESS cycle of a push.
    apb(1'b1, A_THRESH, 32'd5, rd, er);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_DATA; pwdata = 32'hBEEF;
    @(posedge clk); #1;
    penable = 1'b1;
    check("rst_mid_we_before", {63'd0, mem_we1}, 64'd1);
    check("rst_mid_wd", 64'(mem_wd1), 64'hBEEF);
    rst_n = 1'b0;
    #1;
    check("rst_mid_we_after", {63'd0, mem_we1}, 64'd0);
    check("rst_mid_pready", {63'd0, pready}, 64'd0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    apb(1'b0, A_STATUS, '0, rd, er);    check("status_after_mid_reset", 64'(rd), 64'h10000);
    apb(1'b0, A_THRESH, '0, rd, er);    check("thresh_after_reset", 64'(rd), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
